lab06_seq_tx: RTL and testbench
===============================

// Module: lab06_seq_tx
// PURPOSE
//  Initiator side of the lab06 number-stream interface. Buffers up to DEPTH 4-bit operands
//  written by a host, then plays them out as one burst: in_valid/in_number/mode.
//  It then waits for the computing block's out_valid/out_result and returns the result
//  to the host, or flags a timeout. Sits between a host/controller and a lab06_1-style core.
// PARAMETERS
//  DEPTH    6    max operands per burst (buffer entries)
//  TIMEOUT  64   cycles to wait in WAIT for out_valid before giving up
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-high
//  wr_en       in   1  host writes wr_data into the next buffer entry
//  wr_data     in   4  operand to buffer
//  start       in   1  host request to send a burst
//  start_mode  in   2  mode value for the burst
//  start_cnt   in   3  operands to send (1..DEPTH)
//  busy        out  1  high in SEND or WAIT
//  in_valid    out  1  burst valid to core
//  in_number   out  4  operand to core
//  mode        out  2  mode to core, valid on first burst beat only
//  out_valid   in   1  core result valid
//  out_result  in   7  core result, signed
//  res_valid   out  1  one-cycle pulse: res_data updated
//  res_data    out  7  last captured result, signed, held until next capture
//  timeout     out  1  one-cycle pulse: WAIT expired without out_valid
// BEHAVIOUR
//  Reset: all outputs 0, buffer entries 0, wr_ptr 0, state IDLE; rst mid-burst aborts immediately.
//  States: IDLE -> SEND -> WAIT -> IDLE. All outputs registered.
//  IDLE: wr_en with wr_ptr<DEPTH stores wr_data at buf[wr_ptr], wr_ptr++.
//   wr_en when full is dropped. wr_en outside IDLE is dropped.
//  IDLE: start with start_cnt>=1 is accepted.
//   cnt = min(start_cnt, DEPTH); mode latched. start_cnt=0 is ignored.
//   start outside IDLE is ignored.
//   Same-cycle wr_en+start: the write is performed first and is visible to the burst.
//  Entries at index >= wr_ptr are sent as their stored values (0 after reset/clear).
//  SEND: the start is accepted at edge k. in_valid=1 for cycles k+1 .. k+cnt, contiguous.
//   in_number=buf[i] for i=0..cnt-1. mode=latched mode on beat 0, else 2'b00.
//   in_number=0 whenever in_valid=0.
//  After the last beat: in_valid drops, wr_ptr clears to 0, state WAIT, wait counter cleared.
//  out_valid during IDLE or SEND is ignored.
//  WAIT: the first out_valid seen at an edge captures out_result into res_data.
//   res_valid=1 for the next cycle; state IDLE.
//  WAIT: the counter increments each cycle without out_valid.
//   When it reaches TIMEOUT: timeout=1 for one cycle, state IDLE, res_data unchanged.
//  out_valid on the same edge as expiry: the capture wins, no timeout.
//  busy=1 exactly while state is SEND or WAIT.
// TESTING
//  T1 reset: assert rst mid-SEND -> in_valid, busy, res_valid, timeout, in_number, mode all 0 same cycle.
//  T2 burst: write 3,7,1, start mode=2 cnt=3.
//     -> in_valid high 3 cycles: in_number 3,7,1; mode 2,0,0.
//  T3 result: after T2 drive out_valid with out_result=-5 after 4 cycles.
//     -> res_valid 1 cycle, res_data=7'h7B, busy low next cycle.
//  T4 timeout: burst of 1, no out_valid.
//     -> timeout pulses at WAIT cycle TIMEOUT, res_data unchanged, new start accepted after.
//  T5 boundaries: 7 writes with DEPTH=6, 7th dropped; start_cnt=7 clamped -> 6 beats.
//     start_cnt=0 ignored; start while busy ignored.
//  T6 simultaneous: wr_en=9 with start cnt=1 on an empty buffer -> single beat in_number=9.
//     out_valid on the expiry edge -> res_valid, no timeout.

Source files
------------

// File: rtl/lab06_seq_tx.sv
// lab06 number-stream initiator: buffers host operands, plays them out
// as one burst, then collects the core result or flags a timeout.
module lab06_seq_tx #(
  parameter int DEPTH   = 6,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       start,
  input  logic [1:0] start_mode,
  input  logic [2:0] start_cnt,
  output logic       busy,
  output logic       in_valid,
  output logic [3:0] in_number,
  output logic [1:0] mode,
  input  logic       out_valid,
  input  logic [6:0] out_result,
  output logic       res_valid,
  output logic [6:0] res_data,
  output logic       timeout
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t        state, state_d;
  logic [3:0]    mem   [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] cnt, cnt_d;
  logic [PW-1:0] bidx, bidx_d;
  logic [WW-1:0] wcnt, wcnt_d;

  logic       busy_d;
  logic       in_valid_d;
  logic [3:0] in_number_d;
  logic [1:0] mode_d;
  logic       res_valid_d;
  logic [6:0] res_data_d;
  logic       timeout_d;

  always_comb begin
    state_d     = state;
    mem_d       = mem;
    wr_ptr_d    = wr_ptr;
    cnt_d       = cnt;
    bidx_d      = bidx;
    wcnt_d      = wcnt;
    in_valid_d  = 1'b0;
    in_number_d = 4'd0;
    mode_d      = 2'b00;
    res_valid_d = 1'b0;
    res_data_d  = res_data;
    timeout_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_en && (wr_ptr < PW'(DEPTH))) begin
          mem_d[wr_ptr] = wr_data;
          wr_ptr_d      = wr_ptr + 1'b1;
        end
        // beat 0 reads mem_d so a same-cycle write is forwarded
        if (start && (start_cnt != 3'd0)) begin
          state_d     = SEND;
          cnt_d       = (int'(start_cnt) > DEPTH)
                      ? PW'(DEPTH) : PW'(start_cnt);
          bidx_d      = PW'(1);
          in_valid_d  = 1'b1;
          in_number_d = mem_d[0];
          mode_d      = start_mode;
        end
      end

      SEND: begin
        if (bidx < cnt) begin
          in_valid_d  = 1'b1;
          in_number_d = mem[bidx];
          bidx_d      = bidx + 1'b1;
        end else begin
          state_d  = WAIT;
          wr_ptr_d = '0;
          wcnt_d   = '0;
        end
      end

      WAIT: begin
        if (out_valid) begin
          res_data_d  = out_result;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wcnt_d = wcnt + 1'b1;
          if (wcnt_d == WW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
      wr_ptr    <= '0;
      cnt       <= '0;
      bidx      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      in_valid  <= 1'b0;
      in_number <= 4'd0;
      mode      <= 2'b00;
      res_valid <= 1'b0;
      res_data  <= 7'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      mem       <= mem_d;
      wr_ptr    <= wr_ptr_d;
      cnt       <= cnt_d;
      bidx      <= bidx_d;
      wcnt      <= wcnt_d;
      busy      <= busy_d;
      in_valid  <= in_valid_d;
      in_number <= in_number_d;
      mode      <= mode_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_lab06_seq_tx.sv
// Bench for lab06_seq_tx: directed steps plus randomized bursts
// checked against an operand-list model of the host buffer.
module tb_lab06_seq_tx;

  localparam int DEPTH = 6;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       start;
  logic [1:0] start_mode;
  logic [2:0] start_cnt;
  logic       busy;
  logic       in_valid;
  logic [3:0] in_number;
  logic [1:0] mode;
  logic       out_valid;
  logic [6:0] out_result;
  logic       res_valid;
  logic [6:0] res_data;
  logic       timeout;

  lab06_seq_tx #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .start_mode (start_mode),
    .start_cnt  (start_cnt),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_number  (in_number),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_result (out_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mbuf [DEPTH];
  int         mptr;
  logic [6:0] mres;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 4'd0;
    mptr = 0;
    mres = 7'd0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_inv"}, 32'(in_valid), 0);
    chk({tag, "_num"}, 32'(in_number), 0);
    chk({tag, "_mode"}, 32'(mode), 0);
    chk({tag, "_resv"}, 32'(res_valid), 0);
    chk({tag, "_tmo"}, 32'(timeout), 0);
  endtask

  task automatic wr(input logic [3:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (mptr < DEPTH) begin
      mbuf[mptr] = d;
      mptr++;
    end
  endtask

  task automatic run_burst(input int c, input logic [1:0] m,
                           input bit sw, input logic [3:0] sd);
    int n;
    n = (c > DEPTH) ? DEPTH : c;
    if (sw) begin
      wr_en   = 1'b1;
      wr_data = sd;
      if (mptr < DEPTH) begin
        mbuf[mptr] = sd;
        mptr++;
      end
    end
    start      = 1'b1;
    start_cnt  = 3'(c);
    start_mode = m;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("beat%0d_v", i), 32'(in_valid), 1);
      chk($sformatf("beat%0d_num", i), 32'(in_number), 32'(mbuf[i]));
      chk($sformatf("beat%0d_mode", i), 32'(mode),
          (i == 0) ? 32'(m) : 0);
      chk($sformatf("beat%0d_busy", i), 32'(busy), 1);
      chk($sformatf("beat%0d_resv", i), 32'(res_valid), 0);
      out_valid  = 1'b1;
      out_result = 7'h11;
      tick();
    end
    out_valid = 1'b0;
    chk("post_burst_v", 32'(in_valid), 0);
    chk("post_burst_num", 32'(in_number), 0);
    chk("post_burst_busy", 32'(busy), 1);
    chk("post_burst_resv", 32'(res_valid), 0);
    mptr = 0;
  endtask

  task automatic wait_phase(input int dly, input logic [6:0] r,
                            input bit noise);
    for (int j = 0; j <= TO; j++) begin
      start = 1'b0;
      wr_en = 1'b0;
      if (j == dly && dly < TO) begin
        out_valid  = 1'b1;
        out_result = r;
        tick();
        out_valid = 1'b0;
        mres = r;
        chk("cap_resv", 32'(res_valid), 1);
        chk("cap_data", 32'(res_data), 32'(mres));
        chk("cap_tmo", 32'(timeout), 0);
        chk("cap_busy", 32'(busy), 0);
        tick();
        chk("cap_resv_pulse", 32'(res_valid), 0);
        chk("cap_idle_busy", 32'(busy), 0);
        chk("cap_idle_inv", 32'(in_valid), 0);
        return;
      end
      if (j == TO) begin
        chk("tmo_pulse", 32'(timeout), 1);
        chk("tmo_resv", 32'(res_valid), 0);
        chk("tmo_data", 32'(res_data), 32'(mres));
        chk("tmo_busy", 32'(busy), 0);
        tick();
        chk("tmo_pulse_end", 32'(timeout), 0);
        return;
      end
      chk($sformatf("wait%0d_busy", j), 32'(busy), 1);
      chk($sformatf("wait%0d_tmo", j), 32'(timeout), 0);
      chk($sformatf("wait%0d_inv", j), 32'(in_valid), 0);
      if (noise) begin
        start     = 1'b1;
        start_cnt = 3'd3;
        wr_en     = 1'b1;
        wr_data   = 4'hF;
      end
      tick();
    end
  endtask

  initial begin
    int nw, c, dly;
    logic [1:0] m;
    logic [6:0] r;
    bit sw;

    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 4'd0;
    start      = 1'b0;
    start_mode = 2'b00;
    start_cnt  = 3'd0;
    out_valid  = 1'b0;
    out_result = 7'd0;
    model_reset();
    #12;
    chk_idle_outs("rst0");
    chk("rst0_data", 32'(res_data), 0);
    tick();
    rst = 1'b0;
    tick();

    // T1: reset in the middle of a burst
    wr(4'h1);
    wr(4'h2);
    wr(4'h3);
    start      = 1'b1;
    start_cnt  = 3'd3;
    start_mode = 2'd1;
    tick();
    start = 1'b0;
    tick();
    chk("t1_pre_inv", 32'(in_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk_idle_outs("t1");
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    run_burst(6, 2'd3, 1'b0, 4'd0);
    wait_phase(1, 7'h22, 1'b0);

    // T2/T3: basic burst and signed result
    wr(4'd3);
    wr(4'd7);
    wr(4'd1);
    run_burst(3, 2'd2, 1'b0, 4'd0);
    wait_phase(4, 7'h7B, 1'b0);
    chk("t3_data", 32'(res_data), 32'h7B);

    // T4: timeout keeps old result
    run_burst(1, 2'd1, 1'b0, 4'd0);
    wait_phase(TO, 7'h00, 1'b0);
    chk("t4_data_held", 32'(res_data), 32'h7B);

    // T5: overflow write, clamp, ignored starts and writes
    wr(4'hA);
    wr(4'hB);
    wr(4'hC);
    wr(4'hD);
    wr(4'hE);
    wr(4'h6);
    wr(4'h8);
    run_burst(7, 2'd3, 1'b0, 4'd0);
    wait_phase(2, 7'h3F, 1'b1);
    start     = 1'b1;
    start_cnt = 3'd0;
    tick();
    start = 1'b0;
    chk("t5_cnt0_busy", 32'(busy), 0);
    chk("t5_cnt0_inv", 32'(in_valid), 0);
    tick();
    chk("t5_cnt0_busy2", 32'(busy), 0);

    // T6: same-cycle write+start, capture on expiry edge
    run_burst(1, 2'd0, 1'b1, 4'd9);
    wait_phase(TO - 1, 7'h40, 1'b0);

    for (int it = 0; it < 10; it++) begin
      nw = $urandom_range(0, 7);
      for (int k = 0; k < nw; k++) wr(4'($urandom));
      c   = $urandom_range(1, 7);
      m   = 2'($urandom);
      sw  = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 3) == 0) ? TO : $urandom_range(0, 12);
      r   = 7'($urandom);
      run_burst(c, m, sw, 4'($urandom));
      wait_phase(dly, r, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
